// File: rtl/vga_board_adapter.sv
// Board glue for a VGA pattern core: power-on reset, two-stage registered colour/sync
// path, per-sync pin polarity. Define VGA_ADAPTER_DITHER_EN for 4x4 Bayer dithering.
module vga_board_adapter #(
   parameter int IN_BITS      = 6,
   parameter int OUT_BITS     = 2,
   parameter int POR_CYCLES   = 3,
   parameter int IN_SYNC_LOW  = 1,
   parameter int HSYNC_INV    = 0,
   parameter int VSYNC_INV    = 0,
   parameter int PIX_DIV_LOG2 = 0
) (
   input  logic                clk48,
   input  logic                rst_n,
   output logic                core_rst_n,
   input  logic [IN_BITS-1:0]  in_r,
   input  logic [IN_BITS-1:0]  in_g,
   input  logic [IN_BITS-1:0]  in_b,
   input  logic                in_hsync,
   input  logic                in_vsync,
   output logic [OUT_BITS-1:0] pin_r,
   output logic [OUT_BITS-1:0] pin_g,
   output logic [OUT_BITS-1:0] pin_b,
   output logic                pin_hsync,
   output logic                pin_vsync
);

   localparam int         D         = IN_BITS - OUT_BITS;
   localparam logic       SYNC_IDLE = (IN_SYNC_LOW != 0);
   localparam logic       HS_RST    = SYNC_IDLE ^ (HSYNC_INV != 0);
   localparam logic       VS_RST    = SYNC_IDLE ^ (VSYNC_INV != 0);
   localparam logic [7:0] POR_INIT  = 8'(POR_CYCLES);

   logic [7:0]          r_por_cnt    = POR_INIT;
   logic                r_core_rst_n = 1'b0;
   logic [IN_BITS-1:0]  r_s1_r       = '0;
   logic [IN_BITS-1:0]  r_s1_g       = '0;
   logic [IN_BITS-1:0]  r_s1_b       = '0;
   logic                r_s1_hs      = SYNC_IDLE;
   logic                r_s1_vs      = SYNC_IDLE;
   logic [OUT_BITS-1:0] r_pin_r      = '0;
   logic [OUT_BITS-1:0] r_pin_g      = '0;
   logic [OUT_BITS-1:0] r_pin_b      = '0;
   logic                r_pin_hs     = HS_RST;
   logic                r_pin_vs     = VS_RST;
   logic [OUT_BITS-1:0] w_q_r, w_q_g, w_q_b;

   // core_rst_n rises on edge POR_CYCLES+1 after release.
   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         r_por_cnt    <= POR_INIT;
         r_core_rst_n <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values; r_core_rst_n sees the old count.
         if (r_por_cnt != 8'd0) r_por_cnt <= r_por_cnt - 8'd1;
         r_core_rst_n <= (r_por_cnt == 8'd0);
      end
   end

   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_r  <= '0;
         r_s1_g  <= '0;
         r_s1_b  <= '0;
         r_s1_hs <= SYNC_IDLE;
         r_s1_vs <= SYNC_IDLE;
      end else begin
         r_s1_r  <= in_r;
         r_s1_g  <= in_g;
         r_s1_b  <= in_b;
         r_s1_hs <= in_hsync;
         r_s1_vs <= in_vsync;
      end
   end

`ifdef VGA_ADAPTER_DITHER_EN
   localparam int                  SUB_W    = (PIX_DIV_LOG2 > 0) ? PIX_DIV_LOG2 : 1;
   localparam logic [SUB_W-1:0]    SUB_LAST = SUB_W'((1 << PIX_DIV_LOG2) - 1);
   localparam int                  SHL      = (D >= 4) ? D - 4 : 0;
   localparam int                  SHR      = (D >= 4) ? 0 : 4 - D;
   localparam logic [IN_BITS-1:0]  RES_MASK = IN_BITS'((1 << D) - 1);
   localparam logic [3:0]          BAYER [16] = '{
      4'd0,  4'd8,  4'd2,  4'd10,
      4'd12, 4'd4,  4'd14, 4'd6,
      4'd3,  4'd11, 4'd1,  4'd9,
      4'd15, 4'd7,  4'd13, 4'd5
   };

   logic [SUB_W-1:0] r_sub_cnt = '0;
   logic [1:0]       r_x       = '0;
   logic [1:0]       r_y       = '0;
   logic [1:0]       r_s1_x    = '0;
   logic [1:0]       r_s1_y    = '0;
   logic             w_hs_edge, w_vs_edge, w_sub_wrap;
   logic [3:0]       w_t;

   assign w_hs_edge  = (in_hsync != SYNC_IDLE) && (r_s1_hs == SYNC_IDLE);
   assign w_vs_edge  = (in_vsync != SYNC_IDLE) && (r_s1_vs == SYNC_IDLE);
   assign w_sub_wrap = (PIX_DIV_LOG2 == 0) || (r_sub_cnt == SUB_LAST);

   // The pixel sampled on a sync edge keeps the old position; the next one starts at x=0.
   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         r_sub_cnt <= '0;
         r_x       <= '0;
         r_y       <= '0;
         r_s1_x    <= '0;
         r_s1_y    <= '0;
      end else begin
         if (w_hs_edge) begin
            r_sub_cnt <= '0;
            r_x       <= '0;
         end else begin
            r_sub_cnt <= w_sub_wrap ? '0 : r_sub_cnt + 1'b1;
            if (w_sub_wrap) r_x <= r_x + 2'd1;
         end
         if (w_vs_edge)      r_y <= '0;
         else if (w_hs_edge) r_y <= r_y + 2'd1;
         r_s1_x <= r_x;
         r_s1_y <= r_y;
      end
   end

   assign w_t = BAYER[{r_s1_y, r_s1_x}];

   function automatic logic [OUT_BITS-1:0] f_quant(input logic [IN_BITS-1:0] v,
                                                   input logic [3:0] t);
      logic [OUT_BITS-1:0] hi;
      logic [IN_BITS-1:0]  res;
      logic [IN_BITS+3:0]  thr;
      hi  = OUT_BITS'(v >> D);
      res = v & RES_MASK;
      thr = ({{IN_BITS{1'b0}}, t} << SHL) >> SHR;
      if (({4'b0000, res} > thr) && (hi != '1)) return hi + OUT_BITS'(1);
      return hi;
   endfunction

   assign w_q_r = f_quant(r_s1_r, w_t);
   assign w_q_g = f_quant(r_s1_g, w_t);
   assign w_q_b = f_quant(r_s1_b, w_t);
`else
   function automatic logic [OUT_BITS-1:0] f_quant(input logic [IN_BITS-1:0] v);
      return OUT_BITS'(v >> D);
   endfunction

   assign w_q_r = f_quant(r_s1_r);
   assign w_q_g = f_quant(r_s1_g);
   assign w_q_b = f_quant(r_s1_b);
`endif

   // Pins hold reset values until the core itself is out of reset.
   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         r_pin_r  <= '0;
         r_pin_g  <= '0;
         r_pin_b  <= '0;
         r_pin_hs <= HS_RST;
         r_pin_vs <= VS_RST;
      end else if (!r_core_rst_n) begin
         r_pin_r  <= '0;
         r_pin_g  <= '0;
         r_pin_b  <= '0;
         r_pin_hs <= HS_RST;
         r_pin_vs <= VS_RST;
      end else begin
         r_pin_r  <= w_q_r;
         r_pin_g  <= w_q_g;
         r_pin_b  <= w_q_b;
         r_pin_hs <= r_s1_hs ^ (HSYNC_INV != 0);
         r_pin_vs <= r_s1_vs ^ (VSYNC_INV != 0);
      end
   end

   assign core_rst_n = r_core_rst_n;
   assign pin_r      = r_pin_r;
   assign pin_g      = r_pin_g;
   assign pin_b      = r_pin_b;
   assign pin_hsync  = r_pin_hs;
   assign pin_vsync  = r_pin_vs;

endmodule

// File: tb/tb_vga_board_adapter.sv
// Directed bench for vga_board_adapter: three parameter sets driven in lockstep,
// expectations hand-computed; dither checks apply when VGA_ADAPTER_DITHER_EN is defined.
module tb_vga_board_adapter;

   logic clk48 = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk48 = ~clk48;

   int n_cmp = 0;
   int n_bad = 0;

   // dut0: default parameters
   logic [5:0] a_r, a_g, a_b;
   logic       a_hs, a_vs, a_core, a_phs, a_pvs;
   logic [1:0] a_pr, a_pg, a_pb;
   // dut1: POR_CYCLES=0, HSYNC_INV=1, PIX_DIV_LOG2=1
   logic [5:0] b_r, b_g, b_b;
   logic       b_hs, b_vs, b_core, b_phs, b_pvs;
   logic [1:0] b_pr, b_pg, b_pb;
   // dut2: 4->4 pass-through, active-high syncs, VSYNC_INV=1, POR_CYCLES=1
   logic [3:0] c_r, c_g, c_b;
   logic       c_hs, c_vs, c_core, c_phs, c_pvs;
   logic [3:0] c_pr, c_pg, c_pb;

   localparam logic [5:0] PIX_A = 6'b010001;

   vga_board_adapter u_dut0 (
      .clk48(clk48), .rst_n(rst_n), .core_rst_n(a_core),
      .in_r(a_r), .in_g(a_g), .in_b(a_b), .in_hsync(a_hs), .in_vsync(a_vs),
      .pin_r(a_pr), .pin_g(a_pg), .pin_b(a_pb), .pin_hsync(a_phs), .pin_vsync(a_pvs));

   vga_board_adapter #(.POR_CYCLES(0), .HSYNC_INV(1), .PIX_DIV_LOG2(1)) u_dut1 (
      .clk48(clk48), .rst_n(rst_n), .core_rst_n(b_core),
      .in_r(b_r), .in_g(b_g), .in_b(b_b), .in_hsync(b_hs), .in_vsync(b_vs),
      .pin_r(b_pr), .pin_g(b_pg), .pin_b(b_pb), .pin_hsync(b_phs), .pin_vsync(b_pvs));

   vga_board_adapter #(.IN_BITS(4), .OUT_BITS(4), .POR_CYCLES(1), .IN_SYNC_LOW(0),
                       .VSYNC_INV(1)) u_dut2 (
      .clk48(clk48), .rst_n(rst_n), .core_rst_n(c_core),
      .in_r(c_r), .in_g(c_g), .in_b(c_b), .in_hsync(c_hs), .in_vsync(c_vs),
      .pin_r(c_pr), .pin_g(c_pg), .pin_b(c_pb), .pin_hsync(c_phs), .pin_vsync(c_pvs));

   task automatic tick();
      @(posedge clk48);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      a_r = 6'h3F; a_g = 6'h3F; a_b = 6'h3F; a_hs = 1'b1; a_vs = 1'b1;
      b_r = 6'h3F; b_g = 6'h00; b_b = 6'h00; b_hs = 1'b1; b_vs = 1'b1;
      c_r = 4'hF;  c_g = 4'h0;  c_b = 4'h0;  c_hs = 1'b0; c_vs = 1'b0;
      tick();
      tick();
      check("rst_core0", a_core, 1'b0);
      check("rst_pin_r0", a_pr, 2'b00);
      check("rst_hs0", a_phs, 1'b1);
      check("rst_vs0", a_pvs, 1'b1);
      check("rst_core1", b_core, 1'b0);
      check("rst_hs1_inv", b_phs, 1'b0);
      check("rst_hs2_high", c_phs, 1'b0);
      check("rst_vs2_inv", c_pvs, 1'b1);

      // Power-on reset: release between edges, count edges from here
      rst_n = 1'b1;
      tick();
      check("por_e1_core0", a_core, 1'b0);
      check("por_e1_pin_r0", a_pr, 2'b00);
      check("por_e1_core1", b_core, 1'b1);
      check("por_e1_core2", c_core, 1'b0);
      tick();
      check("por_e2_core0", a_core, 1'b0);
      check("dut1_pin_r_live", b_pr, 2'b11);
      check("dut1_idle_hs_inv", b_phs, 1'b0);
      check("por_e2_core2", c_core, 1'b1);
      tick();
      check("por_e3_core0", a_core, 1'b0);
      check("por_e3_pin_r0", a_pr, 2'b00);
      check("por_e3_hs0", a_phs, 1'b1);
      check("dut2_pin_r_live", c_pr, 4'hF);
      tick();
      check("por_e4_core0", a_core, 1'b1);
      check("por_e4_pin_r0", a_pr, 2'b00);
      tick();
      check("first_pixel_r0", a_pr, 2'b11);

      // Latency: colour and sync arrive together two clocks after being driven
      a_r = 6'h00; a_g = 6'h00; a_b = 6'h00;
      tick();
      tick();
      check("lat_pre", a_pr, 2'b00);
      a_r = 6'h3F; a_hs = 1'b0; b_hs = 1'b0; c_hs = 1'b1;
      tick();
      a_r = 6'h00; a_hs = 1'b1; b_hs = 1'b1; c_hs = 1'b0;
      check("lat_r_1clk", a_pr, 2'b00);
      check("lat_hs_1clk", a_phs, 1'b1);
      tick();
      check("lat_r_2clk", a_pr, 2'b11);
      check("lat_hs_2clk", a_phs, 1'b0);
      check("dut1_hs_active_inv", b_phs, 1'b1);
      check("dut2_hs_active_high", c_phs, 1'b1);
      tick();
      check("lat_r_3clk", a_pr, 2'b00);
      check("lat_hs_3clk", a_phs, 1'b1);
      check("dut1_hs_idle_again", b_phs, 1'b0);

      // Pass-through when IN_BITS == OUT_BITS
      c_r = 4'hA; c_g = 4'h5; c_b = 4'hC;
      tick();
      tick();
      check("pass_r", c_pr, 4'hA);
      check("pass_g", c_pg, 4'h5);
      check("pass_b", c_pb, 4'hC);

`ifdef VGA_ADAPTER_DITHER_EN
      // Coincident hsync+vsync edge puts the next pixel at x=0, y=0
      a_hs = 1'b0; a_vs = 1'b0;
      tick();
      a_hs = 1'b1; a_vs = 1'b1; a_r = PIX_A;
      tick();
      a_r = PIX_A;
      tick();
      check("dith_x0_thr0", a_pr, 2'b10);
      a_r = 6'b010011;
      tick();
      check("dith_x1_thr8", a_pr, 2'b01);
      a_r = 6'h00;
      tick();
      check("dith_x2_thr2", a_pr, 2'b10);

      // One hsync edge: y=1, x=0 -> threshold 12
      a_hs = 1'b0;
      tick();
      a_hs = 1'b1; a_r = PIX_A;
      tick();
      a_r = 6'h00;
      tick();
      check("dith_y1_thr12", a_pr, 2'b01);

      // Coincident edges from y=1: clear wins
      a_hs = 1'b0; a_vs = 1'b0;
      tick();
      a_hs = 1'b1; a_vs = 1'b1; a_r = PIX_A;
      tick();
      a_r = 6'h00;
      tick();
      check("dith_coincident_y0", a_pr, 2'b10);

      // Four hsync edges wrap y back to 0
      for (int i = 0; i < 3; i++) begin
         a_hs = 1'b0;
         tick();
         a_hs = 1'b1;
         tick();
      end
      a_hs = 1'b0;
      tick();
      a_hs = 1'b1; a_r = PIX_A;
      tick();
      a_r = 6'h00;
      tick();
      check("dith_y_wrap", a_pr, 2'b10);

      // Saturation at all 16 Bayer positions
      a_r = 6'h3F; a_hs = 1'b0; a_vs = 1'b0;
      tick();
      a_hs = 1'b1; a_vs = 1'b1;
      for (int row = 0; row < 4; row++) begin
         if (row > 0) begin
            a_hs = 1'b0;
            tick();
            a_hs = 1'b1;
            check("dith_sat_edge", a_pr, 2'b11);
         end
         for (int col = 0; col < 4; col++) begin
            tick();
            check("dith_sat", a_pr, 2'b11);
         end
      end

      // PIX_DIV_LOG2=1: x steps every second clock
      b_hs = 1'b0; b_vs = 1'b0;
      tick();
      b_hs = 1'b1; b_vs = 1'b1; b_r = PIX_A;
      tick();
      tick();
      check("div2_px0_x0", b_pr, 2'b10);
      tick();
      check("div2_px1_x0", b_pr, 2'b10);
      tick();
      check("div2_px2_x1", b_pr, 2'b01);
      tick();
      check("div2_px3_x1", b_pr, 2'b01);
`else
      // Truncation keeps the upper OUT_BITS
      a_r = 6'b011111; a_g = 6'b100000; a_b = 6'b101010; b_r = 6'b010000;
      tick();
      tick();
      check("trunc_r", a_pr, 2'b01);
      check("trunc_g", a_pg, 2'b10);
      check("trunc_b", a_pb, 2'b10);
      check("trunc_dut1_r", b_pr, 2'b01);
      a_r = 6'b000011; a_g = 6'h3F; a_b = 6'b110000;
      tick();
      tick();
      check("trunc_r_low", a_pr, 2'b00);
      check("trunc_g_max", a_pg, 2'b11);
      check("trunc_b_hi", a_pb, 2'b11);
`endif

      // Asynchronous reset mid-line, then POR restarts
      a_r = 6'h3F; a_g = 6'h00; a_b = 6'h00; b_hs = 1'b0;
      tick();
      tick();
      check("pre_reset_r", a_pr, 2'b11);
      check("pre_reset_core", a_core, 1'b1);
      check("pre_reset_hs1", b_phs, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_core0", a_core, 1'b0);
      check("async_pin_r0", a_pr, 2'b00);
      check("async_hs0", a_phs, 1'b1);
      check("async_vs0", a_pvs, 1'b1);
      check("async_core1", b_core, 1'b0);
      check("async_hs1_inv", b_phs, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      tick();
      check("por_restart_e3", a_core, 1'b0);
      tick();
      check("por_restart_e4", a_core, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
